// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Results and flags are registered at the done edge and held until the next completed operation.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    // state | meaning
    // IDLE  | waiting for start; result registers hold the last completed operation
    // RUN   | one full-subtractor step per clock, bit idx of the latched operands
    // DONE  | done pulse cycle; returns to IDLE unconditionally
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] shadow;
    logic [IDXW-1:0]  idx;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] shadow_next;
    logic             last_bit;

    assign busy     = (state_q != IDLE);
    assign last_bit = (idx == IDX_LAST);

    always_comb begin
        d_bit       = a_sh[0] ^ b_sh[0] ^ br;
        br_next     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        shadow_next = {d_bit, shadow[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            shadow <= '0;
            idx    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= bin;
                        idx    <= '0;
                        shadow <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    shadow <= shadow_next;
                    br     <= br_next;
                    idx    <= idx + IDX_ONE;
                    // The final step's cell outputs go straight into the result registers.
                    if (last_bit) begin
                        diff <= shadow_next;
                        bout <= br_next;
                        zero <= (shadow_next == '0);
                        ovf  <= (a_msb != b_msb) && (shadow_next[WIDTH-1] != a_msb);
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): arithmetic reference model checked every
// cycle, plus directed operations with hand-computed literal results.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf),
        .zero (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since acceptance, result from plain integer arithmetic.
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_zero = 1'b0;
    logic [W-1:0] p_diff;
    logic         p_bout;
    logic         p_ovf;
    logic         p_zero;

    always @(posedge clk) begin
        int ia, ib, sa, sb, full, sd;
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
            m_ovf  = 1'b0;
            m_zero = 1'b0;
        end else if (m_cnt == 0) begin
            m_done = 1'b0;
            if (start) begin
                ia = int'(a);
                ib = int'(b);
                sa = (ia >= 8) ? ia - 16 : ia;
                sb = (ib >= 8) ? ib - 16 : ib;
                full = ia - ib - int'(bin);
                sd = sa - sb - int'(bin);
                p_diff = W'(full & 15);
                p_bout = (ia < ib + int'(bin));
                p_ovf  = (sd > 7) || (sd < -8);
                p_zero = ((full & 15) == 0);
                m_cnt  = 1;
            end
        end else if (m_cnt == W) begin
            m_done = 1'b1;
            m_diff = p_diff;
            m_bout = p_bout;
            m_ovf  = p_ovf;
            m_zero = p_zero;
            m_cnt  = W + 1;
        end else if (m_cnt == W + 1) begin
            m_done = 1'b0;
            m_cnt  = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_cnt != 0));
            check("done", int'(done), int'(m_done));
            check("diff", int'(diff), int'(m_diff));
            check("bout", int'(bout), int'(m_bout));
            check("ovf", int'(ovf), int'(m_ovf));
            check("zero", int'(zero), int'(m_zero));
            if (done) done_cnt++;
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input int ed, input int eb, input int eo, input int ez, input string nm);
        int n;
        int busy_cyc;
        int seen;
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_cyc = 0; seen = 0;
        while (busy && n < 20) begin
            busy_cyc++;
            if (done) seen++;
            @(negedge clk);
            n++;
        end
        check({nm, " busy_cycles"}, busy_cyc, 5);
        check({nm, " done_pulses"}, seen, 1);
        check({nm, " diff"}, int'(diff), ed);
        check({nm, " bout"}, int'(bout), eb);
        check({nm, " ovf"}, int'(ovf), eo);
        check({nm, " zero"}, int'(zero), ez);
    endtask

    initial begin
        int n;
        int dc0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset diff", int'(diff), 0);
        check("reset flags", int'({bout, ovf, zero}), 0);
        rst = 1'b0;

        run_op(4'd7,  4'd3,  1'b0, 4,  0, 0, 0, "7-3");
        run_op(4'd3,  4'd7,  1'b0, 12, 1, 0, 0, "3-7");
        run_op(4'd8,  4'd1,  1'b0, 7,  0, 1, 0, "8-1");
        run_op(4'd5,  4'd5,  1'b0, 0,  0, 0, 1, "5-5");
        run_op(4'd0,  4'd0,  1'b1, 15, 1, 0, 0, "0-0-1");
        run_op(4'd15, 4'd15, 1'b1, 15, 1, 0, 0, "15-15-1");
        run_op(4'd4,  4'd9,  1'b0, 11, 1, 1, 0, "4-9");

        // Starts during RUN and during DONE must be ignored.
        dc0 = done_cnt;
        @(negedge clk);
        a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd2; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ign done seen", int'(done), 1);
        a = 4'd2; b = 4'd9; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("ign done count", done_cnt - dc0, 1);
        check("ign diff", int'(diff), 4);
        check("ign busy", int'(busy), 0);

        // Reset at the second RUN edge discards the operation.
        dc0 = done_cnt;
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst diff", int'(diff), 0);
        check("midrst flags", int'({bout, ovf, zero}), 0);
        repeat (10) @(negedge clk);
        check("midrst no done", done_cnt - dc0, 0);

        // Reset and start on the same edge: reset wins.
        rst = 1'b1; start = 1'b1; a = 4'd6; b = 4'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("rst+start idle", int'(busy), 0);

        run_op(4'd8, 4'd1, 1'b0, 7, 0, 1, 0, "post-rst 8-1");
        run_op(4'd6, 4'd2, 1'b1, 3, 0, 0, 0, "6-2-1");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
